// File: rtl/pcie_rb_pkg.sv
// Shared types and constants for the PCIe ring-buffer writer family.
package pcie_rb_pkg;

  // Default ring slot address width used by the PDU path.
  localparam int PDU_AWIDTH = 12;

  // Header flit field offsets and widths.
  localparam int HDR_LEN_LSB   = 0;
  localparam int HDR_LEN_W     = 32;
  localparam int HDR_CH_LSB    = 32;
  localparam int HDR_CH_W      = 8;
  localparam int HDR_TRUNC_BIT = 47;
  localparam int HDR_FLITS_LSB = 48;
  localparam int HDR_FLITS_W   = 16;
  localparam int HDR_W         = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_HDR  = 2'd2
  } wr_state_e;

  // Packed header, MSB first: flits[63:48], trunc[47], zero[46:40], ch[39:32], len[31:0].
  typedef struct packed {
    logic [HDR_FLITS_W-1:0] flits;
    logic                   trunc;
    logic [6:0]             rsvd;
    logic [HDR_CH_W-1:0]    channel;
    logic [HDR_LEN_W-1:0]   len;
  } rb_hdr_t;

  function automatic rb_hdr_t make_hdr(input logic [HDR_LEN_W-1:0] len,
                                       input logic [HDR_CH_W-1:0] channel,
                                       input logic trunc,
                                       input logic [HDR_FLITS_W-1:0] flits);
    rb_hdr_t h;
    h.flits   = flits;
    h.trunc   = trunc;
    h.rsvd    = '0;
    h.channel = channel;
    h.len     = len;
    return h;
  endfunction

  // Status counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the last grant.
module rr_arbiter #(
  parameter int N = 4,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] grant_idx;
  logic          found;

  // Pick the first requester at or after the rotating pointer.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[(int'(ptr_reg) + i) % N]) begin
        found                        = 1'b1;
        grant[(int'(ptr_reg) + i) % N] = 1'b1;
        grant_idx                    = IW'((int'(ptr_reg) + i) % N);
      end
    end
  end

  // Move priority past the channel that was just served.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (advance && found) begin
      ptr_reg <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/pcie_rb_mc_writer.sv
// Multi-channel packet writer into the host PCIe ring buffer with back-filled headers.
module pcie_rb_mc_writer
  import pcie_rb_pkg::*;
#(
  parameter int NUM_CH        = 4,
  parameter int DATA_W        = 512,
  parameter int AWIDTH        = PDU_AWIDTH,
  parameter int RB_DEPTH      = 2**AWIDTH,
  parameter int MAX_PKT_FLITS = 32,
  localparam int EW = $clog2(DATA_W/8),
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  input  logic [NUM_CH*EW-1:0]     in_empty,
  input  logic [NUM_CH-1:0]        in_sop,
  input  logic [NUM_CH-1:0]        in_eop,
  input  logic [NUM_CH-1:0]        in_valid,
  output logic [NUM_CH-1:0]        in_ready,
  output logic [DATA_W-1:0]        pcie_rb_wr_data,
  output logic [AWIDTH-1:0]        pcie_rb_wr_addr,
  output logic                     pcie_rb_wr_en,
  input  logic [AWIDTH-1:0]        pcie_rb_rd_ptr,
  output logic                     pcie_rb_update_valid,
  output logic [AWIDTH-1:0]        pcie_rb_update_size,
  input  logic                     disable_pcie,
  output logic [31:0]              pkt_cnt,
  output logic [31:0]              drop_cnt,
  output logic [31:0]              trunc_cnt
);

  localparam int FW = $clog2(MAX_PKT_FLITS + 1);

  wr_state_e         state_reg, state_next;
  logic [CW-1:0]     ch_reg;
  logic [AWIDTH-1:0] hdr_addr_reg;
  logic              drop_reg;
  logic [FW-1:0]     flits_reg;
  logic [31:0]       bytes_reg;
  logic              trunc_reg;
  logic [AWIDTH-1:0] wr_ptr_reg;

  // Per-channel views of the flattened input buses.
  logic [DATA_W-1:0] ch_data  [NUM_CH];
  logic [EW-1:0]     ch_empty [NUM_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_unpack
    assign ch_data[gi]  = in_data[gi*DATA_W +: DATA_W];
    assign ch_empty[gi] = in_empty[gi*EW +: EW];
  end

  // Free slots; one slot always stays empty to tell full from empty.
  logic [AWIDTH-1:0] used_slots;
  logic [AWIDTH:0]   free_slots;
  logic              room;

  assign used_slots = wr_ptr_reg - pcie_rb_rd_ptr;
  assign free_slots = (AWIDTH+1)'(RB_DEPTH - 1) - {1'b0, used_slots};
  assign room       = free_slots >= (AWIDTH+1)'(MAX_PKT_FLITS + 1);

  // Only a channel whose head flit starts a packet may compete.
  logic [NUM_CH-1:0] arb_grant;
  logic [CW-1:0]     arb_idx;
  logic              grant_fire;

  rr_arbiter #(.N(NUM_CH)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (in_valid & in_sop),
    .advance(grant_fire),
    .grant  (arb_grant)
  );

  // One-hot grant to channel index.
  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (arb_grant[i]) arb_idx = CW'(i);
    end
  end

  assign grant_fire = (state_reg == ST_IDLE) && (|arb_grant) && room;

  logic              flit_fire;
  logic              store;
  logic [DATA_W-1:0] cur_data;
  logic [EW-1:0]     cur_empty;
  rb_hdr_t           hdr_word;

  assign cur_data  = ch_data[ch_reg];
  assign cur_empty = ch_empty[ch_reg];
  assign flit_fire = (state_reg == ST_DATA) && in_valid[ch_reg];
  assign store     = !drop_reg && (flits_reg < FW'(MAX_PKT_FLITS));
  assign hdr_word  = make_hdr(bytes_reg, HDR_CH_W'(ch_reg), trunc_reg, HDR_FLITS_W'(flits_reg));

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state and the ready steering to the granted channel.
  always_comb begin
    state_next = state_reg;
    in_ready   = '0;
    case (state_reg)
      ST_IDLE: if (grant_fire) state_next = ST_DATA;
      ST_DATA: begin
        in_ready[ch_reg] = 1'b1;
        if (flit_fire && in_eop[ch_reg]) state_next = ST_HDR;
      end
      ST_HDR:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Per-packet context: captured at grant, accumulated per flit, committed in HDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_reg       <= '0;
      hdr_addr_reg <= '0;
      drop_reg     <= 1'b0;
      flits_reg    <= '0;
      bytes_reg    <= '0;
      trunc_reg    <= 1'b0;
      wr_ptr_reg   <= '0;
    end else begin
      if (grant_fire) begin
        ch_reg       <= arb_idx;
        hdr_addr_reg <= wr_ptr_reg;
        drop_reg     <= disable_pcie;
        flits_reg    <= '0;
        bytes_reg    <= '0;
        trunc_reg    <= 1'b0;
      end else if (flit_fire) begin
        bytes_reg <= bytes_reg + (32'(DATA_W/8) - 32'(cur_empty));
        if (store) flits_reg <= flits_reg + FW'(1);
        if (flits_reg >= FW'(MAX_PKT_FLITS)) trunc_reg <= 1'b1;
      end
      if (state_reg == ST_HDR && !drop_reg) begin
        wr_ptr_reg <= wr_ptr_reg + AWIDTH'(flits_reg) + AWIDTH'(1);
      end
    end
  end

  // Registered ring write port; header and update leave together after HDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcie_rb_wr_en        <= 1'b0;
      pcie_rb_wr_addr      <= '0;
      pcie_rb_wr_data      <= '0;
      pcie_rb_update_valid <= 1'b0;
      pcie_rb_update_size  <= '0;
    end else begin
      pcie_rb_wr_en        <= 1'b0;
      pcie_rb_update_valid <= 1'b0;
      if (flit_fire && store) begin
        pcie_rb_wr_en   <= 1'b1;
        pcie_rb_wr_addr <= hdr_addr_reg + AWIDTH'(flits_reg) + AWIDTH'(1);
        pcie_rb_wr_data <= cur_data;
      end else if (state_reg == ST_HDR && !drop_reg) begin
        pcie_rb_wr_en        <= 1'b1;
        pcie_rb_wr_addr      <= hdr_addr_reg;
        pcie_rb_wr_data      <= {{(DATA_W-HDR_W){1'b0}}, hdr_word};
        pcie_rb_update_valid <= 1'b1;
        pcie_rb_update_size  <= AWIDTH'(flits_reg) + AWIDTH'(1);
      end
    end
  end

  // Saturating status counters, bumped once per packet in HDR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt   <= '0;
      drop_cnt  <= '0;
      trunc_cnt <= '0;
    end else if (state_reg == ST_HDR) begin
      if (drop_reg) begin
        drop_cnt <= sat_inc(drop_cnt);
      end else begin
        pkt_cnt <= sat_inc(pkt_cnt);
        if (trunc_reg) trunc_cnt <= sat_inc(trunc_cnt);
      end
    end
  end

endmodule

// File: tb/tb_pcie_rb_mc_writer.sv
// Scoreboard bench for pcie_rb_mc_writer: reference model predicts ring writes and updates.
module tb_pcie_rb_mc_writer;

  localparam int NUM_CH        = 4;
  localparam int DATA_W        = 512;
  localparam int AWIDTH        = 6;
  localparam int RB_DEPTH      = 64;
  localparam int MAX_PKT_FLITS = 32;
  localparam int EW            = 6;
  localparam int BPF           = DATA_W / 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [NUM_CH*EW-1:0]     in_empty;
  logic [NUM_CH-1:0]        in_sop, in_eop, in_valid, in_ready;
  logic [DATA_W-1:0]        pcie_rb_wr_data;
  logic [AWIDTH-1:0]        pcie_rb_wr_addr;
  logic                     pcie_rb_wr_en;
  logic [AWIDTH-1:0]        pcie_rb_rd_ptr;
  logic                     pcie_rb_update_valid;
  logic [AWIDTH-1:0]        pcie_rb_update_size;
  logic                     disable_pcie;
  logic [31:0]              pkt_cnt, drop_cnt, trunc_cnt;

  logic [AWIDTH-1:0] consumed_ptr;
  logic [AWIDTH-1:0] rd_adjust;
  assign pcie_rb_rd_ptr = consumed_ptr - rd_adjust;

  always #5 clk = ~clk;

  pcie_rb_mc_writer #(
    .NUM_CH(NUM_CH), .DATA_W(DATA_W), .AWIDTH(AWIDTH),
    .RB_DEPTH(RB_DEPTH), .MAX_PKT_FLITS(MAX_PKT_FLITS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_empty(in_empty), .in_sop(in_sop), .in_eop(in_eop),
    .in_valid(in_valid), .in_ready(in_ready),
    .pcie_rb_wr_data(pcie_rb_wr_data), .pcie_rb_wr_addr(pcie_rb_wr_addr),
    .pcie_rb_wr_en(pcie_rb_wr_en), .pcie_rb_rd_ptr(pcie_rb_rd_ptr),
    .pcie_rb_update_valid(pcie_rb_update_valid), .pcie_rb_update_size(pcie_rb_update_size),
    .disable_pcie(disable_pcie),
    .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
  );

  typedef struct {
    int len;
    int empty;
    int seed;
    bit midsop;
  } pkt_t;

  typedef struct {
    logic [AWIDTH-1:0] addr;
    logic [DATA_W-1:0] data;
    bit                is_hdr;
  } wr_t;

  pkt_t ch_q  [NUM_CH][$];
  pkt_t pend  [NUM_CH][$];
  wr_t  exp_wr_q[$];
  int   exp_upd_q[$];

  int n_checks = 0;
  int n_pass   = 0;
  int stuck_ch = -1;

  int m_wr, m_rr, m_pkt, m_drop, m_trunc;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, expv);
  endtask

  function automatic logic [DATA_W-1:0] flit_data(input int ch, input int seed, input int idx);
    logic [DATA_W-1:0] d;
    for (int w = 0; w < DATA_W/32; w++)
      d[w*32 +: 32] = 32'(seed*977 + idx*131 + w*7 + ch*100003) ^ 32'h5a5a_0000;
    return d;
  endfunction

  // Reference model: one packet's worth of ring writes, update and counters.
  task automatic model_pkt(input int c, input pkt_t p, input bit drop);
    int stored;
    bit tr;
    logic [DATA_W-1:0] hdr;
    if (drop) begin
      m_drop++;
      return;
    end
    stored = (p.len < MAX_PKT_FLITS) ? p.len : MAX_PKT_FLITS;
    tr     = p.len > MAX_PKT_FLITS;
    for (int i = 0; i < stored; i++)
      exp_wr_q.push_back('{addr: AWIDTH'((m_wr + 1 + i) % RB_DEPTH),
                           data: flit_data(c, p.seed, i), is_hdr: 1'b0});
    hdr          = '0;
    hdr[31:0]    = 32'(p.len * BPF - p.empty);
    hdr[39:32]   = 8'(c);
    hdr[47]      = tr;
    hdr[63:48]   = 16'(stored);
    exp_wr_q.push_back('{addr: AWIDTH'(m_wr), data: hdr, is_hdr: 1'b1});
    exp_upd_q.push_back(stored + 1);
    m_wr = (m_wr + stored + 1) % RB_DEPTH;
    m_pkt++;
    if (tr) m_trunc++;
  endtask

  // Hand the pending packets to the drivers and predict the round-robin service order.
  task automatic issue(input bit drop);
    int c, total;
    for (int k = 0; k < NUM_CH; k++)
      foreach (pend[k][j]) ch_q[k].push_back(pend[k][j]);
    total = 0;
    for (int k = 0; k < NUM_CH; k++) total += pend[k].size();
    while (total > 0) begin
      c = -1;
      for (int k = 0; k < NUM_CH; k++)
        if (c < 0 && pend[(m_rr + k) % NUM_CH].size() > 0) c = (m_rr + k) % NUM_CH;
      model_pkt(c, pend[c].pop_front(), drop);
      m_rr = (c + 1) % NUM_CH;
      total--;
    end
  endtask

  function automatic int outstanding();
    int n = exp_wr_q.size() + exp_upd_q.size();
    for (int k = 0; k < NUM_CH; k++) n += ch_q[k].size();
    return n;
  endfunction

  task automatic wait_drain(input int budget);
    int n = 0;
    while (outstanding() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("drain_outstanding", 64'(outstanding()), 64'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_wr = 0; m_rr = 0; m_pkt = 0; m_drop = 0; m_trunc = 0;
  endtask

  task automatic add_pkt(input int c, input int len, input int empty, input bit midsop);
    pend[c].push_back('{len: len, empty: empty, seed: int'($urandom_range(0, 65535)), midsop: midsop});
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_pkt_cnt"},   64'(pkt_cnt),   64'(m_pkt));
    chk({tag, "_drop_cnt"},  64'(drop_cnt),  64'(m_drop));
    chk({tag, "_trunc_cnt"}, 64'(trunc_cnt), 64'(m_trunc));
  endtask

  // Source drivers for all channels: present head packet, advance on handshake.
  int  cur_idx [NUM_CH];
  bit  busy    [NUM_CH];
  bit  hs      [NUM_CH];
  initial begin
    in_valid = '0; in_sop = '0; in_eop = '0; in_data = '0; in_empty = '0;
    for (int c = 0; c < NUM_CH; c++) begin busy[c] = 1'b0; cur_idx[c] = 0; end
    forever begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) hs[c] = in_valid[c] && in_ready[c];
      @(posedge clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hs[c] && busy[c]) begin
          cur_idx[c]++;
          if (cur_idx[c] == ch_q[c][0].len) begin
            void'(ch_q[c].pop_front());
            busy[c] = 1'b0;
          end
        end
        if (!busy[c] && ch_q[c].size() > 0) begin
          busy[c]    = 1'b1;
          cur_idx[c] = 0;
        end
        if (busy[c]) begin
          in_valid[c] = 1'b1;
          in_sop[c]   = (cur_idx[c] == 0) || (ch_q[c][0].midsop && cur_idx[c] == 1);
          in_eop[c]   = (cur_idx[c] == ch_q[c][0].len - 1);
          in_data[c*DATA_W +: DATA_W] = flit_data(c, ch_q[c][0].seed, cur_idx[c]);
          in_empty[c*EW +: EW] = in_eop[c] ? EW'(ch_q[c][0].empty) : '0;
        end else if (c == stuck_ch) begin
          in_valid[c] = 1'b1;
          in_sop[c]   = 1'b0;
          in_eop[c]   = 1'b0;
          in_data[c*DATA_W +: DATA_W] = flit_data(c, 7, 99);
          in_empty[c*EW +: EW] = '0;
        end else begin
          in_valid[c] = 1'b0;
          in_sop[c]   = 1'b0;
          in_eop[c]   = 1'b0;
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the ring port is active; host consumes on update.
  initial begin
    wr_t e;
    int  s;
    bit  hdr_seen;
    forever begin
      @(negedge clk);
      if (rst) begin
        consumed_ptr = '0;
        continue;
      end
      hdr_seen = 1'b0;
      if (pcie_rb_wr_en) begin
        if (exp_wr_q.size() == 0) begin
          chk("unexpected_write_addr", 64'(pcie_rb_wr_addr), 64'hFFFF);
        end else begin
          e = exp_wr_q.pop_front();
          $display("write addr=%0d hdr=%0d lo=%h", pcie_rb_wr_addr, e.is_hdr, pcie_rb_wr_data[63:0]);
          chk("wr_addr", 64'(pcie_rb_wr_addr), 64'(e.addr));
          chk_data(e.is_hdr ? "hdr_data" : "wr_data", pcie_rb_wr_data, e.data);
          hdr_seen = e.is_hdr;
        end
      end
      if (pcie_rb_update_valid) begin
        chk("update_with_hdr", 64'(hdr_seen), 64'd1);
        if (exp_upd_q.size() == 0) begin
          chk("unexpected_update_size", 64'(pcie_rb_update_size), 64'hFFFF);
        end else begin
          s = exp_upd_q.pop_front();
          $display("update size=%0d", pcie_rb_update_size);
          chk("update_size", 64'(pcie_rb_update_size), 64'(s));
          consumed_ptr = consumed_ptr + AWIDTH'(s);
        end
      end
    end
  end

  initial begin
    int n;
    bit drop;
    rst = 1'b1; disable_pcie = 1'b0; rd_adjust = '0;
    m_wr = 0; m_rr = 0; m_pkt = 0; m_drop = 0; m_trunc = 0;
    repeat (3) @(negedge clk);
    // Reset state while held in reset.
    chk("rst_wr_en", 64'(pcie_rb_wr_en), 64'd0);
    chk("rst_wr_addr", 64'(pcie_rb_wr_addr), 64'd0);
    chk("rst_upd_valid", 64'(pcie_rb_update_valid), 64'd0);
    chk("rst_upd_size", 64'(pcie_rb_update_size), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_counters("rst");
    rst = 1'b0;
    @(negedge clk);

    // Single 3-flit packet on channel 2 with empty=4.
    add_pkt(2, 3, 4, 1'b0);
    issue(1'b0);
    wait_drain(300);
    chk_counters("single");

    // All channels at once from reset priority, then channel 0 leads again.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) add_pkt(c, 1, $urandom_range(0, 63), 1'b0);
    issue(1'b0);
    wait_drain(300);
    add_pkt(1, 1, 0, 1'b0);
    add_pkt(0, 1, 0, 1'b0);
    issue(1'b0);
    wait_drain(300);
    chk_counters("rr");

    // Wrap: bring wr_ptr to RB_DEPTH-2 then send 3 flits, then one more packet from slot 2.
    do_reset();
    add_pkt(1, 31, 0, 1'b0);
    add_pkt(1, 29, 0, 1'b0);
    issue(1'b0);
    wait_drain(500);
    add_pkt(3, 3, 10, 1'b0);
    issue(1'b0);
    wait_drain(300);
    add_pkt(0, 1, 0, 1'b0);
    issue(1'b0);
    wait_drain(300);
    chk_counters("wrap");

    // Full ring: free = MAX_PKT_FLITS blocks, one more consumed slot releases.
    rd_adjust = AWIDTH'(31);
    add_pkt(2, 1, 0, 1'b0);
    issue(1'b0);
    repeat (6) begin
      @(negedge clk);
      chk("full_in_ready", 64'(in_ready), 64'd0);
    end
    rd_adjust = AWIDTH'(30);
    @(negedge clk);
    chk("release_in_ready", 64'(in_ready), 64'b0100);
    wait_drain(300);
    rd_adjust = '0;

    // Oversize packet: 40 flits accepted, 32 stored.
    add_pkt(1, 40, 0, 1'b0);
    issue(1'b0);
    wait_drain(500);
    chk_counters("trunc");

    // Drop: disable at grant, released mid-packet.
    disable_pcie = 1'b1;
    add_pkt(3, 5, 0, 1'b0);
    issue(1'b1);
    n = 0;
    while (!in_ready[3] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drop_granted", 64'(in_ready[3]), 64'd1);
    disable_pcie = 1'b0;
    wait_drain(300);
    chk_counters("drop");

    // A head flit without sop must never be granted.
    stuck_ch = 0;
    add_pkt(2, 2, 3, 1'b0);
    issue(1'b0);
    wait_drain(300);
    stuck_ch = -1;
    repeat (2) @(negedge clk);

    // Randomised batches across channels.
    for (int r = 0; r < 12; r++) begin
      drop = ($urandom_range(0, 5) == 0);
      disable_pcie = drop;
      for (int c = 0; c < NUM_CH; c++) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++)
          add_pkt(c, ($urandom_range(0, 3) == 0) ? $urandom_range(20, 40) : $urandom_range(1, 5),
                  $urandom_range(0, 63), $urandom_range(0, 3) == 0);
      end
      issue(drop);
      wait_drain(3000);
      disable_pcie = 1'b0;
    end
    chk_counters("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
